// File: rtl/mem_param_slave.sv
// mem_param_slave
//   Word-addressed memory slave behind a simple valid/ready handshake.
//   A request is captured in IDLE. A write completes one cycle later and
//   commits at the end of that cycle. A read completes RD_LATENCY cycles
//   after capture. Addresses at or beyond DEPTH are flagged with err in
//   the completion cycle. They never touch the memory and read back as 0.
//
//   Optional feature: define MEM_BYTE_STROBE_EN to make writes honour
//   wstrb per byte lane. Without it every write replaces the full word.

module mem_param_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic                    wr_rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err
);

  // Index width actually needed to address DEPTH words.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH widened by one bit so that DEPTH == 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  // Latency counter compare points; RD_LATENCY is limited to 1..4.
  localparam logic [2:0] LP_LAT    = 3'(RD_LATENCY);
  localparam logic [2:0] LP_LAT_M1 = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  // Captured transaction.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_oor;

  // Cycles elapsed since capture while a read is in flight (1 .. RD_LATENCY).
  logic [2:0]            r_cnt;

  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

`ifdef MEM_BYTE_STROBE_EN
  localparam int NB = DATA_WIDTH / 8;
  logic [NB-1:0]         r_wstrb;
`else
  // Strobes have no effect when byte-lane writes are disabled.
  logic                  w_unused_wstrb;
  assign w_unused_wstrb = ^wstrb;
`endif

  logic                  w_capture;
  logic                  w_in_oor;
  logic                  w_rd_load;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic                  w_ld_oor;
  logic [IW-1:0]         w_ld_idx;
  logic [IW-1:0]         w_wr_idx;

  // A request is only accepted from IDLE. valid seen in any other state,
  // including the completion cycle, is left for the next IDLE cycle.
  assign w_capture = (r_state == IDLE) && valid;

  // Range check on the incoming address, registered together with it.
  assign w_in_oor  = ({1'b0, addr} >= LP_DEPTH);

  // rdata is loaded at the edge that opens the read completion cycle.
  // With a latency of 1 that edge is the capture edge itself, so the
  // address comes straight from the port. Otherwise the captured copy is used.
  assign w_rd_load = (w_capture && !wr_rd && (RD_LATENCY == 1)) ||
                     ((r_state == RD_WAIT) && (r_cnt == LP_LAT_M1));
  assign w_ld_addr = (r_state == IDLE) ? addr     : r_addr;
  assign w_ld_oor  = (r_state == IDLE) ? w_in_oor : r_oor;
  assign w_ld_idx  = w_ld_addr[IW-1:0];
  assign w_wr_idx  = r_addr[IW-1:0];

  // State register: reset returns to IDLE and drops any transaction in flight.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: write takes one cycle, read waits out RD_LATENCY.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (valid) begin
          w_next_state = wr_rd ? WR : RD_WAIT;
        end
      end
      WR: begin
        w_next_state = IDLE;
      end
      RD_WAIT: begin
        if (r_cnt == LP_LAT) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output decode: one-cycle completion pulse, masked while reset is asserted
  // so a transaction cancelled by reset never shows a completion.
  always_comb begin
    ready = 1'b0;
    case (r_state)
      WR:      ready = ~rst;
      RD_WAIT: ready = (r_cnt == LP_LAT) & ~rst;
      default: ready = 1'b0;
    endcase
    err = ready & r_oor;
  end

  assign rdata = r_rdata;

  // Capture the request payload and start the read latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_oor   <= 1'b0;
      r_cnt   <= 3'd0;
`ifdef MEM_BYTE_STROBE_EN
      r_wstrb <= '0;
`endif
    end else begin
      if (w_capture) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_oor   <= w_in_oor;
        r_cnt   <= 3'd1;
`ifdef MEM_BYTE_STROBE_EN
        r_wstrb <= wstrb;
`endif
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  // Read data register: updated only when a read completes, so writes and
  // idle cycles leave the last read value in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_load) begin
      r_rdata <= w_ld_oor ? '0 : r_mem[w_ld_idx];
    end
  end

  // Memory array: write commits at the edge that ends the WR cycle.
  // Out-of-range writes are dropped. Reset wins over a pending commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is cleared on reset because never-written words must read back as 0.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if ((r_state == WR) && !r_oor) begin
`ifdef MEM_BYTE_STROBE_EN
      for (int b = 0; b < NB; b++) begin
        if (r_wstrb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
`else
      r_mem[w_wr_idx] <= r_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_mem_param_slave.sv
// tb_mem_param_slave
//   Directed and random transactions against a DUT built with DEPTH=12 and
//   RD_LATENCY=3. Expected timing, rdata and err come from a word-array
//   model of the memory plus the handshake rules. Honours MEM_BYTE_STROBE_EN.

module tb_mem_param_slave;

  localparam int DW     = 32;
  localparam int AW     = 4;
  localparam int DEPTH  = 12;
  localparam int RD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          wr_rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents and the value rdata must currently hold.
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  mem_param_slave #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .wr_rd (wr_rd),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .ready (ready),
    .rdata (rdata),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500000");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    last_rd = 32'h0;
  endtask

  function automatic logic [31:0] apply_write(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  s);
`ifdef MEM_BYTE_STROBE_EN
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
`else
    return new_w;
`endif
  endfunction

  // Call between edges with the DUT idle; returns at the negedge of the
  // idle cycle that follows completion.
  task automatic txn(input logic w, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit hold, input bit scramble);
    int          lat;
    logic        exp_err;
    logic [31:0] exp_rd;
    bit          seen;
    valid = 1'b1; wr_rd = w; addr = a; wdata = d; wstrb = s;
    exp_err = (int'(a) >= DEPTH);
    exp_rd  = last_rd;
    if (w) begin
      lat = 1;
      if (!exp_err) model[a] = apply_write(model[a], d, s);
    end else begin
      lat = RD_LAT;
      exp_rd = exp_err ? 32'h0 : model[a];
    end
    @(posedge clk);
    if (scramble) begin
      #1;
      addr = 4'($urandom_range(0, 15)); wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15)); wr_rd = ~w;
    end
    seen = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == lat) begin
        last_rd = exp_rd;
        check(w ? "wr_ready" : "rd_ready", ready, 1);
        check(w ? "wr_err" : "rd_err", err, exp_err);
        check(w ? "wr_rdata" : "rd_rdata", rdata, last_rd);
        seen = (ready === 1'b1);
      end else begin
        check("rd_ready_early", ready, 0);
        check("rd_err_early", err, 0);
        check("rd_rdata_hold", rdata, last_rd);
      end
    end
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = (ready === 1'b1);
    end
    @(negedge clk);
    check("idle_ready", ready, 0);
    check("idle_err", err, 0);
    check("idle_rdata", rdata, last_rd);
    if (!hold) valid = 1'b0;
  endtask

  // Capture a request, then assert reset for one cycle in its first cycle.
  task automatic mid_reset(input logic w, input logic [3:0] a, input logic [31:0] d);
    valid = 1'b1; wr_rd = w; addr = a; wdata = d; wstrb = 4'hF;
    @(posedge clk);
    #1; rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1; rst = 1'b0;
    clear_model();
    for (int k = 0; k < RD_LAT; k++) begin
      @(negedge clk);
      check("post_rst_ready", ready, 0);
      check("post_rst_rdata", rdata, 0);
    end
  endtask

  initial begin
    logic [31:0] exp_strb;
    rst = 1'b1; valid = 1'b1; wr_rd = 1'b0; addr = 4'd5; wdata = 32'h0; wstrb = 4'h0;
    clear_model();

    // Reset held two cycles with valid high.
    repeat (2) begin
      @(negedge clk);
      check("reset_ready", ready, 0);
      check("reset_err", err, 0);
      check("reset_rdata", rdata, 0);
    end
    rst = 1'b0;
    txn(1'b0, 4'd5, 32'h0, 4'h0, 1'b0, 1'b0);

    // Write then read back.
    txn(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    txn(1'b0, 4'd3, 32'h0, 4'h0, 1'b0, 1'b0);

    // Out of range, plus the first and last legal/illegal boundaries.
    txn(1'b1, 4'd1,  32'hCAFE0001, 4'hF, 1'b0, 1'b0);
    txn(1'b1, 4'd13, 32'h00000001, 4'hF, 1'b0, 1'b0);
    txn(1'b0, 4'd13, 32'h0, 4'h0, 1'b0, 1'b0);
    txn(1'b0, 4'd1,  32'h0, 4'h0, 1'b0, 1'b0);
    txn(1'b1, 4'd11, 32'h0BADF00D, 4'hF, 1'b0, 1'b0);
    txn(1'b1, 4'd12, 32'h12121212, 4'hF, 1'b0, 1'b0);
    txn(1'b0, 4'd12, 32'h0, 4'h0, 1'b0, 1'b0);
    txn(1'b0, 4'd11, 32'h0, 4'h0, 1'b0, 1'b0);
    txn(1'b0, 4'd15, 32'h0, 4'h0, 1'b0, 1'b0);

    // Byte strobes, including an all-zero strobe write.
    txn(1'b1, 4'd2, 32'h11223344, 4'hF,    1'b0, 1'b0);
    txn(1'b1, 4'd2, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0);
    txn(1'b0, 4'd2, 32'h0, 4'h0, 1'b0, 1'b0);
`ifdef MEM_BYTE_STROBE_EN
    exp_strb = 32'h11BB33DD;
`else
    exp_strb = 32'hAABBCCDD;
`endif
    check("strobe_value", rdata, exp_strb);
    txn(1'b1, 4'd2, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
    txn(1'b0, 4'd2, 32'h0, 4'h0, 1'b0, 1'b0);

    // Back-to-back writes with valid held high, then read them back.
    txn(1'b1, 4'd4, 32'h44444444, 4'hF, 1'b1, 1'b0);
    txn(1'b1, 4'd5, 32'h55555555, 4'hF, 1'b1, 1'b0);
    txn(1'b1, 4'd6, 32'h66666666, 4'hF, 1'b0, 1'b0);
    txn(1'b0, 4'd4, 32'h0, 4'h0, 1'b0, 1'b0);
    txn(1'b0, 4'd5, 32'h0, 4'h0, 1'b0, 1'b0);
    txn(1'b0, 4'd6, 32'h0, 4'h0, 1'b0, 1'b0);

    // Inputs changing after capture must be ignored.
    txn(1'b1, 4'd8, 32'h88888888, 4'hF, 1'b0, 1'b1);
    txn(1'b0, 4'd8, 32'h0, 4'h0, 1'b0, 1'b1);

    // Reset during a pending write commit, then during a read.
    txn(1'b1, 4'd7, 32'h77777777, 4'hF, 1'b0, 1'b0);
    mid_reset(1'b1, 4'd7, 32'h00000055);
    txn(1'b0, 4'd7, 32'h0, 4'h0, 1'b0, 1'b0);
    txn(1'b1, 4'd3, 32'h33333333, 4'hF, 1'b0, 1'b0);
    mid_reset(1'b0, 4'd3, 32'h0);
    txn(1'b0, 4'd3, 32'h0, 4'h0, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
          4'($urandom_range(0, 15)), (n != 79) && ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
